// File: rtl/blowfish_feistel_core_pkg.sv
// Shared definitions for the Blowfish-style Feistel engine: FSM states, mode encoding, round-key index.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package blowfish_pkg;

    // Engine phases: load, request F, wait for F, final un-swap + whitening, hold result
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } feistel_state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Subkey used in round cnt; decryption walks the key schedule backwards
    function automatic int key_index(input int cnt, input logic decrypt, input int rounds);
        return (decrypt == MODE_DEC) ? (rounds + 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/blowfish_feistel_core_if.sv
// Bundle of data-in, data-out, subkey and F-offload signals for the Feistel engine.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready, out_valid/out_ready, ffunc_enable/ffunc_ready handshakes.
interface blowfish_feistel_core_if #(
    parameter int BLOCK_W = 128,
    parameter int ROUNDS  = 8
);
    localparam int HALF_W = BLOCK_W / 2;
    localparam int NK     = ROUNDS + 2;

    logic                   in_valid;
    logic                   in_ready;
    logic [BLOCK_W-1:0]     in_block;
    logic                   in_decrypt;
    logic                   out_valid;
    logic                   out_ready;
    logic [BLOCK_W-1:0]     out_block;
    logic                   skey_ready;
    logic [NK*HALF_W-1:0]   SubKeys;
    logic [HALF_W-1:0]      X;
    logic                   ffunc_enable;
    logic [HALF_W-1:0]      Y;
    logic                   ffunc_ready;

    // Environment side: supplies blocks, keys and F results
    modport master (
        output in_valid, in_block, in_decrypt, out_ready, skey_ready, SubKeys, Y, ffunc_ready,
        input  in_ready, out_valid, out_block, X, ffunc_enable
    );

    // Engine side
    modport slave (
        input  in_valid, in_block, in_decrypt, out_ready, skey_ready, SubKeys, Y, ffunc_ready,
        output in_ready, out_valid, out_block, X, ffunc_enable
    );

endinterface

// File: rtl/blowfish_feistel_core_key_mux.sv
// Selects subkey K[idx_i] out of the flattened subkey array.
// Latency: combinational.
// Backpressure: none.
module blowfish_key_mux #(
    parameter int HALF_W = 64,
    parameter int NK     = 10,
    parameter int IDX_W  = $clog2(NK)
)(
    input  logic [NK*HALF_W-1:0] sub_keys_i,
    input  logic [IDX_W-1:0]     idx_i,
    output logic [HALF_W-1:0]    key_o
);

    // One-hot compare per key slot; out-of-range indices read as zero
    always_comb begin
        key_o = '0;
        for (int i = 0; i < NK; i++) begin
            if (idx_i == IDX_W'(i)) begin
                key_o = sub_keys_i[i*HALF_W +: HALF_W];
            end
        end
    end

endmodule

// File: rtl/blowfish_feistel_core.sv
// Blowfish-style Feistel engine (encrypt/decrypt) with F offloaded over a req/ready handshake.
// Latency: 2*ROUNDS+2 cycles accept-to-out_valid when F answers in the enable cycle; one block in flight.
// Backpressure: in_ready low while busy or keys not ready; result held in DONE until out_ready.
// Optional: define BLOWFISH_ABORT_EN to add the abort input (returns a busy engine to IDLE).
module blowfish_feistel_core
    import blowfish_pkg::*;
#(
    parameter int BLOCK_W = 128,
    parameter int ROUNDS  = 8
)(
    input  logic Clk,
    input  logic RstN,
`ifdef BLOWFISH_ABORT_EN
    input  logic abort,
`endif
    blowfish_feistel_core_if.slave bus
);

    localparam int HALF_W = BLOCK_W / 2;
    localparam int NK     = ROUNDS + 2;
    localparam int CNT_W  = $clog2(ROUNDS + 1);
    localparam int KI_W   = $clog2(NK);

    feistel_state_t     state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               dec_q;
    logic [HALF_W-1:0]  l_q;
    logic [HALF_W-1:0]  r_q;
    logic [HALF_W-1:0]  x_q;
    logic               en_q;
    logic               ovld_q;
    logic [BLOCK_W-1:0] oblk_q;
    logic               live_q;

    logic [KI_W-1:0]    key_idx_d;
    logic [HALF_W-1:0]  k_round_d;
    logic [HALF_W-1:0]  k_fin_l_d;
    logic [HALF_W-1:0]  k_fin_r_d;
    logic [HALF_W-1:0]  fin_l_d;
    logic [HALF_W-1:0]  fin_r_d;
    logic               accept_d;

    assign key_idx_d = KI_W'(key_index(int'(cnt_q), dec_q, ROUNDS));

    blowfish_key_mux #(
        .HALF_W (HALF_W),
        .NK     (NK),
        .IDX_W  (KI_W)
    ) u_key_mux (
        .sub_keys_i (bus.SubKeys),
        .idx_i      (key_idx_d),
        .key_o      (k_round_d)
    );

    // Whitening keys are fixed slots: encrypt uses the two last keys, decrypt the two first
    assign k_fin_l_d = dec_q ? bus.SubKeys[0 +: HALF_W]
                             : bus.SubKeys[(ROUNDS+1)*HALF_W +: HALF_W];
    assign k_fin_r_d = dec_q ? bus.SubKeys[HALF_W +: HALF_W]
                             : bus.SubKeys[ROUNDS*HALF_W +: HALF_W];

    // FINAL swaps the halves back and whitens them in the same step
    assign fin_l_d = r_q ^ k_fin_l_d;
    assign fin_r_d = l_q ^ k_fin_r_d;

    // live_q keeps in_ready low until the first clock after reset release
    assign bus.in_ready = live_q && (state_q == IDLE) && bus.skey_ready;
    assign accept_d     = bus.in_valid && bus.in_ready;

    assign bus.X            = x_q;
    assign bus.ffunc_enable = en_q;
    assign bus.out_valid    = ovld_q;
    assign bus.out_block    = oblk_q;

    // First-clock marker for in_ready
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

    // FSM, round counter and Feistel datapath; all outputs registered here
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dec_q   <= MODE_ENC;
            l_q     <= '0;
            r_q     <= '0;
            x_q     <= '0;
            en_q    <= 1'b0;
            ovld_q  <= 1'b0;
            oblk_q  <= '0;
        end else
`ifdef BLOWFISH_ABORT_EN
        if (abort && (state_q != IDLE)) begin
            // abort wins over any F result or consumer handshake in the same cycle
            state_q <= IDLE;
            cnt_q   <= '0;
            l_q     <= '0;
            r_q     <= '0;
            x_q     <= '0;
            en_q    <= 1'b0;
            ovld_q  <= 1'b0;
        end else
`endif
        begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        l_q     <= bus.in_block[BLOCK_W-1:HALF_W];
                        r_q     <= bus.in_block[HALF_W-1:0];
                        dec_q   <= bus.in_decrypt;
                        cnt_q   <= '0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    x_q     <= l_q ^ k_round_d;
                    en_q    <= 1'b1;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // X and the request stay put until F answers
                    if (bus.ffunc_ready) begin
                        l_q     <= r_q ^ bus.Y;
                        r_q     <= x_q;
                        en_q    <= 1'b0;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= (cnt_q == CNT_W'(ROUNDS - 1)) ? FINAL : REQ;
                    end
                end
                FINAL: begin
                    l_q     <= fin_l_d;
                    r_q     <= fin_r_d;
                    oblk_q  <= {fin_l_d, fin_r_d};
                    ovld_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        ovld_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blowfish_feistel_core.sv
// Self-checking bench: two engine instances (128b/8 rounds and 64b/16 rounds) against a
// classic-Blowfish-loop reference model, with a randomized F responder per instance.
// Optional abort scenario compiled in with BLOWFISH_ABORT_EN.
module tb_blowfish_feistel_core;

    logic Clk  = 1'b0;
    logic RstN = 1'b0;

    blowfish_feistel_core_if #(.BLOCK_W(128), .ROUNDS(8))  bus_a ();
    blowfish_feistel_core_if #(.BLOCK_W(64),  .ROUNDS(16)) bus_b ();

`ifdef BLOWFISH_ABORT_EN
    logic abort_a = 1'b0;
    logic abort_b = 1'b0;
`endif

    blowfish_feistel_core #(.BLOCK_W(128), .ROUNDS(8)) dut_a (
        .Clk   (Clk),
        .RstN  (RstN),
`ifdef BLOWFISH_ABORT_EN
        .abort (abort_a),
`endif
        .bus   (bus_a.slave)
    );

    blowfish_feistel_core #(.BLOCK_W(64), .ROUNDS(16)) dut_b (
        .Clk   (Clk),
        .RstN  (RstN),
`ifdef BLOWFISH_ABORT_EN
        .abort (abort_b),
`endif
        .bus   (bus_b.slave)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Bench knobs
    bit fzero    = 1'b1;   // F returns 0
    int maxd     = 1;      // F answer delay 1..maxd cycles (1 = answer in the cycle enable is seen)
    bit noise    = 1'b0;   // junk ffunc_ready/Y while no request is pending
    bit chk_hold = 1'b0;   // enforce enable held until answered

    logic [63:0] key_a [10];
    logic [31:0] key_b [18];

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] fmod(input logic [63:0] x, input int hw);
        if (fzero) return 64'h0;
        if (hw == 64) return {x[62:0], x[63]} ^ 64'hA5A5_A5A5_A5A5_A5A5;
        return {32'h0, {x[30:0], x[31]} ^ 32'hA5A5_A5A5};
    endfunction

    function automatic logic [63:0] kget(input bit sel, input int i);
        return sel ? {32'h0, key_b[i]} : key_a[i];
    endfunction

    // Classic Blowfish loop: L ^= P; R ^= F(L); swap; then unswap and whiten.
    // Decryption is the same loop over the reversed key schedule.
    function automatic logic [127:0] model(input bit sel, input logic [127:0] blk, input bit dec);
        int          rounds;
        int          hw;
        int          n;
        logic [63:0] xl, xr, t;
        rounds = sel ? 16 : 8;
        hw     = sel ? 32 : 64;
        n      = rounds + 2;
        xl = sel ? {32'h0, blk[63:32]} : blk[127:64];
        xr = sel ? {32'h0, blk[31:0]}  : blk[63:0];
        for (int i = 0; i < rounds; i++) begin
            xl = xl ^ kget(sel, dec ? (n - 1 - i) : i);
            xr = xr ^ fmod(xl, hw);
            t = xl; xl = xr; xr = t;
        end
        t = xl; xl = xr; xr = t;
        xr = xr ^ kget(sel, dec ? (n - 1 - rounds) : rounds);
        xl = xl ^ kget(sel, dec ? (n - 2 - rounds) : rounds + 1);
        return sel ? {64'h0, xl[31:0], xr[31:0]} : {xl, xr};
    endfunction

    task automatic load_keys(input bit zero);
        for (int i = 0; i < 10; i++) begin
            key_a[i] = zero ? 64'h0 : {$urandom, $urandom};
            bus_a.SubKeys[i*64 +: 64] = key_a[i];
        end
        for (int i = 0; i < 18; i++) begin
            key_b[i] = zero ? 32'h0 : $urandom;
            bus_b.SubKeys[i*32 +: 32] = key_b[i];
        end
    endtask

    // F responder for instance A: answers from the X seen when the request first appears
    bit          pend_a, given_a;
    int          rem_a;
    logic [63:0] xs_a;
    always @(negedge Clk) begin
        if (bus_a.ffunc_enable) begin
            if (!pend_a) begin
                pend_a  = 1'b1;
                given_a = 1'b0;
                rem_a   = $urandom_range(1, maxd);
                xs_a    = bus_a.X;
            end
            if (!given_a) begin
                rem_a--;
                if (rem_a == 0) begin
                    bus_a.ffunc_ready = 1'b1;
                    bus_a.Y           = fmod(xs_a, 64);
                    given_a           = 1'b1;
                end else begin
                    bus_a.ffunc_ready = 1'b0;
                    bus_a.Y           = {$urandom, $urandom};
                end
            end
        end else begin
            if (chk_hold && RstN && pend_a && !given_a)
                check_eq("a_en_hold", bus_a.ffunc_enable, 1'b1);
            pend_a            = 1'b0;
            bus_a.ffunc_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_a.Y           = {$urandom, $urandom};
        end
    end

    // F responder for instance B
    bit          pend_b, given_b;
    int          rem_b;
    logic [31:0] xs_b;
    always @(negedge Clk) begin
        if (bus_b.ffunc_enable) begin
            if (!pend_b) begin
                pend_b  = 1'b1;
                given_b = 1'b0;
                rem_b   = $urandom_range(1, maxd);
                xs_b    = bus_b.X;
            end
            if (!given_b) begin
                rem_b--;
                if (rem_b == 0) begin
                    bus_b.ffunc_ready = 1'b1;
                    bus_b.Y           = 32'(fmod({32'h0, xs_b}, 32));
                    given_b           = 1'b1;
                end else begin
                    bus_b.ffunc_ready = 1'b0;
                    bus_b.Y           = $urandom;
                end
            end
        end else begin
            if (chk_hold && RstN && pend_b && !given_b)
                check_eq("b_en_hold", bus_b.ffunc_enable, 1'b1);
            pend_b            = 1'b0;
            bus_b.ffunc_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus_b.Y           = $urandom;
        end
    end

    function automatic logic ov(input bit sel);
        return sel ? bus_b.out_valid : bus_a.out_valid;
    endfunction

    function automatic logic ir(input bit sel);
        return sel ? bus_b.in_ready : bus_a.in_ready;
    endfunction

    function automatic logic [127:0] ob(input bit sel);
        return sel ? {64'h0, bus_b.out_block} : bus_a.out_block;
    endfunction

    // Offer a block at a negedge, return at the negedge after the accepting edge
    task automatic start_block(input bit sel, input logic [127:0] blk, input bit dec, output bit ok);
        int n = 0;
        if (sel) begin
            bus_b.in_block = blk[63:0]; bus_b.in_decrypt = dec; bus_b.in_valid = 1'b1;
        end else begin
            bus_a.in_block = blk;       bus_a.in_decrypt = dec; bus_a.in_valid = 1'b1;
        end
        while (!ir(sel) && n < 100) begin
            @(negedge Clk);
            n++;
        end
        ok = ir(sel);
        if (!ok) check_eq("accept_timeout", ir(sel), 1'b1);
        else begin
            @(posedge Clk);
            @(negedge Clk);
        end
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
    endtask

    // Latency counts the accepting edge as cycle 1; hold keeps out_ready low that many cycles
    task automatic finish_block(input bit sel, input int hold, output logic [127:0] res, output int lat);
        lat = 1;
        while (!ov(sel) && lat < 500) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
        end
        if (!ov(sel)) check_eq("out_timeout", ov(sel), 1'b1);
        res = ob(sel);
        for (int i = 0; i < hold; i++) begin
            @(posedge Clk);
            @(negedge Clk);
            check_eq("hold_vld", ov(sel), 1'b1);
            check_eq("hold_blk", ob(sel), res);
            check_eq("hold_rdy", ir(sel), 1'b0);
        end
        if (sel) bus_b.out_ready = 1'b1; else bus_a.out_ready = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        bus_a.out_ready = 1'b0;
        bus_b.out_ready = 1'b0;
        check_eq("vld_drop", ov(sel), 1'b0);
        check_eq("rdy_back", ir(sel), sel ? bus_b.skey_ready : bus_a.skey_ready);
    endtask

    task automatic run(input bit sel, input logic [127:0] blk, input bit dec, input int hold,
                       output logic [127:0] res, output int lat);
        bit ok;
        start_block(sel, blk, dec, ok);
        res = '0;
        lat = 0;
        if (ok) finish_block(sel, hold, res, lat);
    endtask

    // Stop at the negedge where instance A has just raised its request for round r
    task automatic wait_round(input int r);
        int   seen = 0;
        int   n    = 0;
        logic prev = 1'b0;
        while (seen < r + 1 && n < 400) begin
            @(negedge Clk);
            n++;
            if (bus_a.ffunc_enable && !prev) seen++;
            prev = bus_a.ffunc_enable;
        end
        if (seen < r + 1) check_eq("round_timeout", seen, r + 1);
    endtask

    initial begin
        logic [127:0] p, c, d;
        int           lat;
        bit           ok;
        bit           seen;

        bus_a.in_valid = 1'b0; bus_a.in_block = '0; bus_a.in_decrypt = 1'b0; bus_a.out_ready = 1'b0;
        bus_a.skey_ready = 1'b1; bus_a.Y = '0; bus_a.ffunc_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_block = '0; bus_b.in_decrypt = 1'b0; bus_b.out_ready = 1'b0;
        bus_b.skey_ready = 1'b1; bus_b.Y = '0; bus_b.ffunc_ready = 1'b0;
        load_keys(1'b1);

        // Reset values
        #1;
        check_eq("rst_vld", bus_a.out_valid, 1'b0);
        check_eq("rst_en",  bus_a.ffunc_enable, 1'b0);
        check_eq("rst_x",   bus_a.X, 64'h0);
        check_eq("rst_blk", bus_a.out_block, 128'h0);
        check_eq("rst_rdy", bus_a.in_ready, 1'b0);
        repeat (3) @(negedge Clk);
        RstN = 1'b1;
        #1;
        check_eq("rdy_pre_clk", bus_a.in_ready, 1'b0);
        @(negedge Clk);
        check_eq("rdy_post_clk", bus_a.in_ready, 1'b1);
        check_eq("rdy_post_clk_b", bus_b.in_ready, 1'b1);

        // Zero keys, zero F: rounds only swap halves
        run(1'b0, 128'h00112233445566778899AABBCCDDEEFF, 1'b0, 0, c, lat);
        check_eq("zero_out", c, 128'h8899AABBCCDDEEFF0011223344556677);
        check_eq("zero_lat", lat, 18);

        // Random keys, real F, encrypt then decrypt round trip (with junk F traffic when idle)
        fzero = 1'b0;
        noise = 1'b1;
        load_keys(1'b0);
        for (int i = 0; i < 100; i++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            run(1'b0, p, 1'b0, 0, c, lat);
            check_eq("a_enc", c, model(1'b0, p, 1'b0));
            check_eq("a_lat", lat, 18);
            run(1'b0, c, 1'b1, 0, d, lat);
            check_eq("a_dec", d, p);
        end
        for (int i = 0; i < 100; i++) begin
            p = {64'h0, $urandom, $urandom};
            run(1'b1, p, 1'b0, 0, c, lat);
            check_eq("b_enc", c, model(1'b1, p, 1'b0));
            check_eq("b_lat", lat, 34);
            run(1'b1, c, 1'b1, 0, d, lat);
            check_eq("b_dec", d, p);
            check_eq("b_dec_model", model(1'b1, c, 1'b1), p);
        end

        // Slow F: 1..4 cycle answers must give the same results
        maxd     = 4;
        chk_hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            run(1'b0, p, 1'b0, 0, c, lat);
            check_eq("a_slow_enc", c, model(1'b0, p, 1'b0));
            p = {64'h0, $urandom, $urandom};
            run(1'b1, p, 1'b1, 0, c, lat);
            check_eq("b_slow_dec", c, model(1'b1, p, 1'b1));
        end
        chk_hold = 1'b0;
        maxd     = 1;

        // Consumer stalls 5 cycles in DONE
        p = {$urandom, $urandom, $urandom, $urandom};
        run(1'b0, p, 1'b0, 5, c, lat);
        check_eq("stall_out", c, model(1'b0, p, 1'b0));

        // No keys: offered block must not be taken
        bus_a.skey_ready = 1'b0;
        bus_a.in_block   = p;
        bus_a.in_valid   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check_eq("nokey_rdy", bus_a.in_ready, 1'b0);
        end
        bus_a.in_valid   = 1'b0;
        check_eq("nokey_en", bus_a.ffunc_enable, 1'b0);
        bus_a.skey_ready = 1'b1;
        @(negedge Clk);
        check_eq("nokey_idle", bus_a.in_ready, 1'b1);

        // skey_ready dropping mid-block does not disturb the block
        p = {$urandom, $urandom, $urandom, $urandom};
        start_block(1'b0, p, 1'b0, ok);
        bus_a.skey_ready = 1'b0;
        if (ok) begin
            finish_block(1'b0, 0, c, lat);
            check_eq("skey_drop_out", c, model(1'b0, p, 1'b0));
        end
        bus_a.skey_ready = 1'b1;
        @(negedge Clk);

        // Async reset while waiting on F in round 3
        p = {$urandom, $urandom, $urandom, $urandom};
        start_block(1'b0, p, 1'b0, ok);
        wait_round(3);
        RstN = 1'b0;
        #1;
        check_eq("mid_rst_en",  bus_a.ffunc_enable, 1'b0);
        check_eq("mid_rst_x",   bus_a.X, 64'h0);
        check_eq("mid_rst_vld", bus_a.out_valid, 1'b0);
        check_eq("mid_rst_blk", bus_a.out_block, 128'h0);
        check_eq("mid_rst_rdy", bus_a.in_ready, 1'b0);
        @(negedge Clk);
        RstN = 1'b1;
        @(negedge Clk);
        p = {$urandom, $urandom, $urandom, $urandom};
        run(1'b0, p, 1'b1, 0, c, lat);
        check_eq("post_rst_out", c, model(1'b0, p, 1'b1));

`ifdef BLOWFISH_ABORT_EN
        // Abort while waiting on F in round 5, colliding with the F answer
        p = {$urandom, $urandom, $urandom, $urandom};
        start_block(1'b0, p, 1'b0, ok);
        wait_round(5);
        abort_a = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        abort_a = 1'b0;
        check_eq("abort_en",  bus_a.ffunc_enable, 1'b0);
        check_eq("abort_x",   bus_a.X, 64'h0);
        check_eq("abort_vld", bus_a.out_valid, 1'b0);
        check_eq("abort_rdy", bus_a.in_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clk);
            if (bus_a.out_valid) seen = 1'b1;
        end
        check_eq("abort_no_vld", seen, 1'b0);
        p = {$urandom, $urandom, $urandom, $urandom};
        run(1'b0, p, 1'b0, 0, c, lat);
        check_eq("post_abort_out", c, model(1'b0, p, 1'b0));
`else
        seen = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
